mem_port_arbiter: RTL and testbench

- Shares one memory_slice (2 KiB, byte-addressed, word/half/byte access) between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Runs one access at a time, with round-robin or fixed-priority selection.
- Holds the slice controls stable across the synchronous-read data cycle, because the slice's read-data lane mux is combinational on ren, width and addr[1:0].
- Flags misaligned or illegal accesses without touching memory, and returns a one-cycle response to the owning port.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/rr_arbiter_2.sv | 37 +++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory-slice arbiter.
//   - WIDTH_* : slice width_mode encodings (2'b11 is illegal).
//   - state_e : arbiter FSM states.
//   - mem_req_t : one latched request (store flag, width, sign, byte address, data).
//   - access_legal() : alignment / width legality rule for a request.
package mem_pkg;

  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  width;
    logic        sgn;
    logic [10:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Words must be 4-byte aligned; a half may sit at any offset except 3,
  // where it would straddle two words; bytes are always fine.
  function automatic logic access_legal(input logic [1:0] width, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (width)
      WIDTH_WORD: ok = (addr_lo == 2'b00);
      WIDTH_HALF: ok = (addr_lo != 2'b11);
      WIDTH_BYTE: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester grant logic (purely combinational).
//   valid[1:0]  : requests
//   last_grant  : port granted most recently
//   grant[1:0]  : one-hot grant (zero when nothing is valid)
//   winner      : index of the granted port (meaningful only when grant != 0)
// FIXED_PRIO = 0 : on a conflict, the port that was not granted last wins.
// FIXED_PRIO = 1 : on a conflict, port 0 always wins.
module rr_arbiter_2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    case (valid)
      2'b01: begin
        winner = 1'b0;
        grant  = 2'b01;
      end
      2'b10: begin
        winner = 1'b1;
        grant  = 2'b10;
      end
      2'b11: begin
        winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        grant  = winner ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory slice between port 0 (fetch) and
// port 1 (load/store), one access at a time.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_*             : per-port request (valid/ready, we, width, signed, addr, wdata)
//   rsp_valid[1:0]    : one-cycle response pulse to the owning port
//   rsp_rdata/fault   : shared response payload
//   mem_*             : registered slice controls; mem_rdata is the slice output
//   dbg_state         : current FSM state
//
// Handshake: a port raises req_valid and holds its fields until it sees
// req_ready high at a rising edge; that edge is the accept. req_ready is
// combinational, only ever high in IDLE, and one-hot. Responses are a single
// rsp_valid pulse with no back-pressure.
//
// Flow: IDLE -> ACCESS -> HOLD -> RESP (load), IDLE -> ACCESS -> RESP (store),
// IDLE -> RESP (illegal request, no memory access). The slice's read lane mux
// is combinational on ren/width/addr, so those controls are held unchanged
// through HOLD, the cycle in which read data is captured.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [1:0][1:0]  req_width,
  input  logic [1:0]       req_signed,
  input  logic [1:0][10:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_fault,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [1:0]       mem_width,
  output logic             mem_signed,
  output logic [10:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output state_e           dbg_state
);

  state_e   state_q, state_d;
  mem_req_t req_q, req_d;
  logic     owner_q, owner_d;
  logic     last_grant_q, last_grant_d;
  logic     fault_q, fault_d;

  logic        mem_ren_q, mem_ren_d;
  logic        mem_wen_q, mem_wen_d;
  logic [1:0]  mem_width_q, mem_width_d;
  logic        mem_signed_q, mem_signed_d;
  logic [10:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;

  logic [1:0] grant;
  logic       winner;
  logic       legal;

  rr_arbiter_2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .winner     (winner)
  );

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;

  // State register (all flops)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      fault_q      <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_width_q  <= 2'b00;
      mem_signed_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      fault_q      <= fault_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      mem_width_q  <= mem_width_d;
      mem_signed_q <= mem_signed_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_fault_q  <= rsp_fault_d;
    end
  end

  // Next-state and request latching
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    fault_d      = fault_q;
    legal        = access_legal(req_width[winner], req_addr[winner][1:0]);
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          req_d.we     = req_we[winner];
          req_d.width  = req_width[winner];
          req_d.sgn    = req_signed[winner];
          req_d.addr   = req_addr[winner];
          req_d.wdata  = req_wdata[winner];
          owner_d      = winner;
          last_grant_d = winner;
          fault_d      = ~legal;
          state_d      = legal ? ACCESS : RESP;
        end
      end
      ACCESS:  state_d = req_q.we ? RESP : HOLD;
      HOLD:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the upcoming state so that they
  // line up with the state they belong to.
  always_comb begin
    mem_ren_d    = 1'b0;
    mem_wen_d    = 1'b0;
    mem_width_d  = 2'b00;
    mem_signed_d = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = '0;
    rsp_fault_d  = 1'b0;
    if ((state_d == ACCESS) || (state_d == HOLD)) begin
      mem_addr_d   = req_d.addr;
      mem_width_d  = req_d.width;
      mem_signed_d = req_d.sgn;
      if (req_d.we) begin
        mem_wen_d   = (state_d == ACCESS);
        mem_wdata_d = req_d.wdata;
      end else begin
        mem_ren_d   = 1'b1;
      end
    end
    if (state_d == RESP) begin
      rsp_valid_d[owner_d] = 1'b1;
      rsp_fault_d          = fault_d;
      // Only a load reaches RESP from HOLD; its data is on mem_rdata now.
      if (state_q == HOLD) rsp_rdata_d = mem_rdata;
    end
  end

  assign mem_ren    = mem_ren_q;
  assign mem_wen    = mem_wen_q;
  assign mem_width  = mem_width_q;
  assign mem_signed = mem_signed_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_fault  = rsp_fault_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [1:0]  width;
    logic        sgn;
    logic [10:0] addr;
    logic [31:0] wdata;
  } treq_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_we, req_signed, rsp_valid;
  logic [1:0][1:0]  req_width;
  logic [1:0][10:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [31:0]      rsp_rdata, mem_wdata, mem_rdata;
  logic             rsp_fault, mem_ren, mem_wen, mem_signed;
  logic [1:0]       mem_width;
  logic [10:0]      mem_addr;
  mem_pkg::state_e  dbg_state;

  // fixed-priority instance: only its grants are observed
  logic [1:0]       f_req_ready, f_rsp_valid, f_mem_width;
  logic [31:0]      f_rsp_rdata, f_mem_wdata;
  logic             f_rsp_fault, f_mem_ren, f_mem_wen, f_mem_signed;
  logic [10:0]      f_mem_addr;
  mem_pkg::state_e  f_dbg_state;

  mem_port_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_width(req_width), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_width(mem_width), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_we(req_we), .req_width(req_width), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(f_rsp_valid),
    .rsp_rdata(f_rsp_rdata), .rsp_fault(f_rsp_fault), .mem_ren(f_mem_ren),
    .mem_wen(f_mem_wen), .mem_width(f_mem_width), .mem_signed(f_mem_signed),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(32'h0),
    .dbg_state(f_dbg_state)
  );

  // ---------------- memory slice model ----------------
  logic [7:0]  slice_mem [0:2047];
  logic [31:0] slice_line, sh;
  logic        slice_clr;

  always @(posedge clk) begin
    if (slice_clr) begin
      for (int i = 0; i < 2048; i++) slice_mem[i] <= 8'h00;
    end else begin
      if (mem_wen) begin
        case (mem_width)
          2'b00: for (int i = 0; i < 4; i++) slice_mem[{mem_addr[10:2], 2'b00} + i] <= mem_wdata[8*i +: 8];
          2'b01: begin
            slice_mem[mem_addr]         <= mem_wdata[7:0];
            slice_mem[mem_addr + 11'd1] <= mem_wdata[15:8];
          end
          2'b10: slice_mem[mem_addr] <= mem_wdata[7:0];
          default: ;
        endcase
      end
      if (mem_ren)
        slice_line <= {slice_mem[{mem_addr[10:2], 2'd3}], slice_mem[{mem_addr[10:2], 2'd2}],
                       slice_mem[{mem_addr[10:2], 2'd1}], slice_mem[{mem_addr[10:2], 2'd0}]};
    end
  end

  always_comb begin
    sh = slice_line >> {mem_addr[1:0], 3'b000};
    mem_rdata = 32'h0;
    if (mem_ren) begin
      case (mem_width)
        2'b00: mem_rdata = slice_line;
        2'b01: mem_rdata = mem_signed ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        2'b10: mem_rdata = mem_signed ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
        default: mem_rdata = 32'h0;
      endcase
    end
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [65:0] exp_q[$];          // {port, fault, rdata, due_cycle}
  treq_t       pq0[$], pq1[$];
  logic [1:0]  hold;
  logic        rand_gap;
  logic        mon_en;
  logic        last_grant_m;
  int          free_cyc;
  int          n_ren_exp = 0, n_wen_exp = 0, n_ren_obs = 0, n_wen_obs = 0;
  logic        acc_seen;
  int          last_acc_port;
  logic [7:0]  ref_mem [0:2047];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_legal(input treq_t r);
    case (r.width)
      2'b00:   return r.addr % 4 == 0;
      2'b01:   return r.addr % 4 != 3;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input treq_t r);
    int a;
    logic [31:0] v;
    a = int'(r.addr);
    case (r.width)
      2'b00: v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      2'b01: begin
        v = {16'h0, ref_mem[a+1], ref_mem[a]};
        if (r.sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: begin
        v = {24'h0, ref_mem[a]};
        if (r.sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
    endcase
    return v;
  endfunction

  task automatic ref_store(input treq_t r);
    int a, n;
    a = int'(r.addr);
    n = (r.width == 2'b00) ? 4 : (r.width == 2'b01) ? 2 : 1;
    for (int i = 0; i < n; i++) ref_mem[a + i] = 8'((r.wdata >> (8 * i)) & 32'hFF);
  endtask

  function automatic logic [1:0] model_ready(input logic [1:0] v);
    if (cyc < free_cyc) return 2'b00;
    case (v)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return last_grant_m ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic treq_t mk(input logic we, input logic [1:0] w, input logic s,
                               input logic [10:0] a, input logic [31:0] d);
    treq_t r;
    r.we = we; r.width = w; r.sgn = s; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic treq_t rand_req();
    logic [1:0] w;
    logic [10:0] a;
    w = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    a = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 63));
    return mk(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  // ---------------- driver ----------------
  task automatic accept(input int p);
    treq_t r;
    logic f;
    logic [31:0] rd;
    int lat, due;
    r = (p == 1) ? pq1.pop_front() : pq0.pop_front();
    hold[p] = 1'b0;
    rd = 32'h0;
    f  = 1'b0;
    if (!ref_legal(r)) begin
      f = 1'b1; lat = 1;
    end else if (r.we) begin
      ref_store(r); lat = 2; n_wen_exp++;
    end else begin
      rd = ref_load(r); lat = 3; n_ren_exp++;
    end
    due = cyc + lat;
    free_cyc = due + 1;
    last_grant_m = (p == 1);
    acc_seen = 1'b1;
    last_acc_port = p;
    exp_q.push_back({(p == 1), f, rd, 32'(due)});
  endtask

  task automatic step();
    treq_t r;
    logic [1:0] acc;
    @(negedge clk);
    if (!rst_n) begin
      req_valid = 2'b00;
      #4;
      return;
    end
    if (!hold[0] && pq0.size() != 0 && (!rand_gap || $urandom_range(0, 2) != 0)) hold[0] = 1'b1;
    if (!hold[1] && pq1.size() != 0 && (!rand_gap || $urandom_range(0, 2) != 0)) hold[1] = 1'b1;
    r = (pq0.size() != 0) ? pq0[0] : '0;
    req_we[0] = r.we; req_width[0] = r.width; req_signed[0] = r.sgn;
    req_addr[0] = r.addr; req_wdata[0] = r.wdata;
    r = (pq1.size() != 0) ? pq1[0] : '0;
    req_we[1] = r.we; req_width[1] = r.width; req_signed[1] = r.sgn;
    req_addr[1] = r.addr; req_wdata[1] = r.wdata;
    req_valid = hold;
    #4;
    if (req_valid != 2'b00) chk("req_ready", 64'(req_ready), 64'(model_ready(req_valid)));
    if (req_valid[0] && f_req_ready != 2'b00) chk("fixed_prio_grant", 64'(f_req_ready), 64'(2'b01));
    acc = req_valid & req_ready;
    if (acc != 2'b00) accept(acc[1] ? 1 : 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pq0.size() != 0 || pq1.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d cycles, %0d responses pending", n, exp_q.size());
      exp_q.delete();
      pq0.delete();
      pq1.delete();
      hold = 2'b00;
    end
    step();
    step();
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 64'({req_ready, rsp_valid, rsp_fault, rsp_rdata, mem_ren, mem_wen,
                   mem_width, mem_signed, mem_addr}), 64'h0);
    chk({name, "_wdata"}, 64'(mem_wdata), 64'h0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    int ren_run, wen_run;
    logic [10:0] ren_addr;
    logic [65:0] e;
    ren_run = 0;
    wen_run = 0;
    ren_addr = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_ren || mem_wen) chk("ren_wen_exclusive", 64'({mem_ren, mem_wen}) & 64'(mem_ren & mem_wen), 64'h0);
        if (mem_ren) begin
          if (ren_run == 0) begin
            ren_addr = mem_addr;
            n_ren_obs++;
          end else begin
            chk("ren_addr_stable", 64'(mem_addr), 64'(ren_addr));
          end
          ren_run++;
        end else if (ren_run != 0) begin
          chk("ren_length", 64'(ren_run), 64'd2);
          ren_run = 0;
        end
        if (mem_wen) begin
          if (wen_run == 0) n_wen_obs++;
          wen_run++;
        end else if (wen_run != 0) begin
          chk("wen_length", 64'(wen_run), 64'd1);
          wen_run = 0;
        end
        if (rsp_valid != 2'b00) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: rsp_valid=%b with nothing pending (cycle %0d)", rsp_valid, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_port", 64'(rsp_valid), e[65] ? 64'd2 : 64'd1);
            chk("rsp_fault", 64'(rsp_fault), 64'(e[64]));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e[63:32]));
            chk("rsp_cycle", 64'(cyc), 64'(e[31:0]));
          end
        end else begin
          chk("rsp_idle_zero", 64'({rsp_fault, rsp_rdata}), 64'h0);
          if (exp_q.size() != 0 && cyc > int'(exp_q[0][31:0])) begin
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL rsp_missing: no response by cycle %0d, expected at %0d", cyc, e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    slice_clr = 1'b1;
    mon_en = 1'b0;
    rand_gap = 1'b0;
    hold = 2'b00;
    req_valid = 2'b00; req_we = 2'b00; req_signed = 2'b00;
    req_width = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    slice_clr = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    last_grant_m = 1'b1;
    free_cyc = 0;

    // directed sequence on port 0
    pq0.push_back(mk(1'b1, 2'b00, 1'b0, 11'h010, 32'hDEAD_BEEF));
    pq0.push_back(mk(1'b0, 2'b00, 1'b0, 11'h010, 32'h0));
    pq0.push_back(mk(1'b0, 2'b10, 1'b1, 11'h013, 32'h0));
    pq0.push_back(mk(1'b0, 2'b10, 1'b0, 11'h013, 32'h0));
    pq0.push_back(mk(1'b0, 2'b00, 1'b0, 11'h012, 32'h0));
    pq0.push_back(mk(1'b0, 2'b01, 1'b0, 11'h013, 32'h0));
    pq0.push_back(mk(1'b0, 2'b11, 1'b0, 11'h010, 32'h0));
    pq0.push_back(mk(1'b1, 2'b00, 1'b0, 11'h011, 32'h1234_5678));
    pq0.push_back(mk(1'b1, 2'b01, 1'b0, 11'h015, 32'h0000_BEEF));
    pq0.push_back(mk(1'b0, 2'b01, 1'b1, 11'h015, 32'h0));
    pq0.push_back(mk(1'b0, 2'b00, 1'b0, 11'h014, 32'h0));
    drain(200);

    // both ports continuously valid
    for (int i = 0; i < 6; i++) begin
      pq0.push_back(rand_req());
      pq1.push_back(rand_req());
    end
    drain(300);

    // random traffic with idle gaps
    rand_gap = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 1) == 1) pq1.push_back(rand_req());
      else pq0.push_back(rand_req());
    end
    drain(2000);
    rand_gap = 1'b0;

    // reset during HOLD of a load
    pq0.push_back(mk(1'b0, 2'b00, 1'b0, 11'h010, 32'h0));
    acc_seen = 1'b0;
    n = 0;
    while (!acc_seen && n < 50) begin
      step();
      n++;
    end
    chk("hold_load_accepted", 64'(acc_seen), 64'd1);
    step();                       // ACCESS cycle
    @(negedge clk);               // HOLD cycle
    rst_n = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    pq0.delete();
    hold = 2'b00;
    free_cyc = 0;
    last_grant_m = 1'b1;
    @(negedge clk);
    check_all_zero("reset_in_hold");
    rst_n = 1'b1;
    pq0.push_back(mk(1'b0, 2'b00, 1'b0, 11'h010, 32'h0));
    pq1.push_back(mk(1'b0, 2'b10, 1'b0, 11'h013, 32'h0));
    acc_seen = 1'b0;
    n = 0;
    while (!acc_seen && n < 20) begin
      step();
      n++;
    end
    chk("post_reset_first_grant", 64'(last_acc_port), 64'd0);
    drain(200);

    chk("ren_count", 64'(n_ren_obs), 64'(n_ren_exp));
    chk("wen_count", 64'(n_wen_obs), 64'(n_wen_exp));
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
